// File: rtl/wave_channel_scheduler_if.sv
// Request/response bus between the channel scheduler and the shared CORDIC core.
// The scheduler side is the master: it issues angle/amplitude with a start
// strobe and receives the core's result with a valid strobe.
`timescale 1ns/1ps
interface wave_channel_scheduler_if #(
  parameter int N_FRAC = 7
);
  logic              core_start;
  logic [N_FRAC:0]   core_phase;
  logic [N_FRAC:0]   core_amp;
  logic              core_valid;
  logic [N_FRAC:0]   core_data;

  modport master (
    output core_start,
    output core_phase,
    output core_amp,
    input  core_valid,
    input  core_data
  );

  modport slave (
    input  core_start,
    input  core_phase,
    input  core_amp,
    output core_valid,
    output core_data
  );
endinterface

// File: rtl/wave_channel_scheduler.sv
// Time-multiplexes one CORDIC core among NUM_CH tone channels. Each sample
// tick walks the enabled channels in ascending order: advance the channel's
// phase accumulator, hand angle and amplitude to the core, wait (bounded) for
// the result and publish it tagged with the channel index.
`timescale 1ns/1ps
module wave_channel_scheduler #(
  parameter int  NUM_CH  = 4,
  parameter int  N_FRAC  = 7,
  parameter int  TIMEOUT = 64,
  localparam int W       = N_FRAC + 1,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [NUM_CH-1:0]   enable_i,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [W-1:0]        cfg_data_i,
  wave_channel_scheduler_if.master core_bus,
  output logic [W-1:0]        sample_o,
  output logic [CH_W-1:0]     sample_ch_o,
  output logic                sample_valid_o,
  output logic                frame_done_o,
  output logic                busy_o,
  input  logic                status_clr_i,
  output logic                overrun_o,
  output logic                timeout_o
);

  // Pointer must be able to hold NUM_CH (one past the last channel).
  localparam int PTR_W = CH_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [W-1:0]        inc_q [NUM_CH];
  logic [W-1:0]        amp_q [NUM_CH];
  logic [W-1:0]        acc_q [NUM_CH];

  logic                start_q, start_d;
  logic [W-1:0]        phase_q, phase_d;
  logic [W-1:0]        ampo_q, ampo_d;
  logic [W-1:0]        sample_q, sample_d;
  logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic [NUM_CH-1:0]   cand_s;
  logic                found_s;
  logic [CH_W-1:0]     sel_ch_s;
  logic [W-1:0]        sum_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                acc_upd_s;
  logic                overrun_ev_s;
  logic                timeout_ev_s;

  // Pick the lowest enabled channel at or above the scan pointer.
  always_comb begin
    cand_s   = '0;
    sel_ch_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_s[i] = mask_q[i] & (PTR_W'(i) >= ptr_q);
      sel_ch_s  = cand_s[i] ? CH_W'(i) : sel_ch_s;
    end
    found_s   = |cand_s;
    sum_s     = acc_q[sel_ch_s] + inc_q[sel_ch_s];
    cnt_inc_s = cnt_q + CNT_W'(1'b1);
  end

  // Frame sequencing: next state, core request and published sample.
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    ptr_d          = ptr_q;
    ch_d           = ch_q;
    cnt_d          = cnt_q;
    start_d        = 1'b0;
    phase_d        = phase_q;
    ampo_d         = ampo_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    acc_upd_s      = 1'b0;
    overrun_ev_s   = 1'b0;
    timeout_ev_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_i) begin
          mask_d = enable_i;
          ptr_d  = '0;
          if (enable_i == '0) begin
            frame_done_d = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        overrun_ev_s = tick_i;
        if (!found_s) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          ch_d      = sel_ch_s;
          acc_upd_s = 1'b1;
          phase_d   = sum_s;
          ampo_d    = amp_q[sel_ch_s];
          start_d   = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        overrun_ev_s = tick_i;
        cnt_d        = cnt_inc_s;
        if (core_bus.core_valid) begin
          sample_d       = core_bus.core_data;
          sample_ch_d    = ch_q;
          sample_valid_d = 1'b1;
          ptr_d          = PTR_W'(ch_q) + PTR_W'(1'b1);
          state_d        = S_SCAN;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          timeout_ev_s = 1'b1;
          ptr_d        = PTR_W'(ch_q) + PTR_W'(1'b1);
          state_d      = S_SCAN;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sticky status flags; a new event beats a simultaneous clear.
  always_comb begin
    if (overrun_ev_s) begin
      overrun_d = 1'b1;
    end else if (status_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (timeout_ev_s) begin
      timeout_d = 1'b1;
    end else if (status_clr_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      ptr_q          <= '0;
      ch_q           <= '0;
      cnt_q          <= '0;
      start_q        <= 1'b0;
      phase_q        <= '0;
      ampo_q         <= '0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      ptr_q          <= ptr_d;
      ch_q           <= ch_d;
      cnt_q          <= cnt_d;
      start_q        <= start_d;
      phase_q        <= phase_d;
      ampo_q         <= ampo_d;
      sample_q       <= sample_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  // Per-channel registers; an accumulator load overrides the scan update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i] <= '0;
        amp_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we_i && (cfg_ch_i == CH_W'(i)) && (cfg_sel_i == 2'd0)) begin
          inc_q[i] <= cfg_data_i;
        end
        if (cfg_we_i && (cfg_ch_i == CH_W'(i)) && (cfg_sel_i == 2'd1)) begin
          amp_q[i] <= cfg_data_i;
        end
        if (cfg_we_i && (cfg_ch_i == CH_W'(i)) && (cfg_sel_i == 2'd2)) begin
          acc_q[i] <= cfg_data_i;
        end else if (acc_upd_s && (sel_ch_s == CH_W'(i))) begin
          acc_q[i] <= sum_s;
        end
      end
    end
  end

  assign core_bus.core_start = start_q;
  assign core_bus.core_phase = phase_q;
  assign core_bus.core_amp   = ampo_q;
  assign sample_o            = sample_q;
  assign sample_ch_o         = sample_ch_q;
  assign sample_valid_o      = sample_valid_q;
  assign frame_done_o        = frame_done_q;
  assign busy_o              = busy_q;
  assign overrun_o           = overrun_q;
  assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_wave_channel_scheduler.sv
// Scoreboard bench for wave_channel_scheduler. Stimulus pushes the expected
// core requests and published samples; a monitor pops and compares them as
// the DUT presents core_start / sample_valid. A simple core model answers
// each request with phase^amp after a fixed latency.
`timescale 1ns/1ps
module tb_wave_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int N_FRAC = 7;
  localparam int W      = N_FRAC + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic [NUM_CH-1:0] enable = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [1:0]        cfg_sel = '0;
  logic [W-1:0]      cfg_data = '0;
  logic              status_clr = 1'b0;
  logic [W-1:0]      sample;
  logic [1:0]        sample_ch;
  logic              sample_valid;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              timeout;

  wave_channel_scheduler_if #(.N_FRAC(N_FRAC)) bus ();

  wave_channel_scheduler #(.NUM_CH(NUM_CH), .N_FRAC(N_FRAC), .TIMEOUT(64)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_i         (tick),
    .enable_i       (enable),
    .cfg_we_i       (cfg_we),
    .cfg_ch_i       (cfg_ch),
    .cfg_sel_i      (cfg_sel),
    .cfg_data_i     (cfg_data),
    .core_bus       (bus),
    .sample_o       (sample),
    .sample_ch_o    (sample_ch),
    .sample_valid_o (sample_valid),
    .frame_done_o   (frame_done),
    .busy_o         (busy),
    .status_clr_i   (status_clr),
    .overrun_o      (overrun),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] ph; logic [7:0] am; } req_t;
  typedef struct packed { logic [1:0] ch; logic [7:0] d; } smp_t;

  req_t exp_req [$];
  smp_t exp_smp [$];

  int tests = 0;
  int failed = 0;
  int frame_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int to_cyc = 0;
  logic to_prev = 1'b0;
  bit drop_en = 1'b0;
  int lat = 16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] ph, input logic [7:0] am, input logic [1:0] ch, input bit drop);
    exp_req.push_back({ph, am});
    if (!drop) exp_smp.push_back({ch, ph ^ am});
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_tick(input logic [3:0] m);
    enable = m; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(posedge clk); #1;
    status_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_frame(input int target);
    int n;
    n = 0;
    while (frame_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done count", frame_cnt, target);
    chk("busy after frame", busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sample_o"}, sample, 8'h00);
    chk({tag, " sample_ch_o"}, sample_ch, 2'd0);
    chk({tag, " sample_valid_o"}, sample_valid, 1'b0);
    chk({tag, " frame_done_o"}, frame_done, 1'b0);
    chk({tag, " busy_o"}, busy, 1'b0);
    chk({tag, " overrun_o"}, overrun, 1'b0);
    chk({tag, " timeout_o"}, timeout, 1'b0);
    chk({tag, " core_start_o"}, bus.core_start, 1'b0);
    chk({tag, " core_phase_o"}, bus.core_phase, 8'h00);
    chk({tag, " core_amp_o"}, bus.core_amp, 8'h00);
  endtask

  // Free-running cycle counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: answer each request with phase^amp after lat cycles.
  initial begin
    logic [7:0] ph;
    logic [7:0] am;
    bus.core_valid = 1'b0;
    bus.core_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.core_start === 1'b1 && !rst) begin
        ph = bus.core_phase;
        am = bus.core_amp;
        if (!(drop_en && am == 8'h55)) begin
          repeat (lat - 1) @(posedge clk);
          #1;
          bus.core_valid = 1'b1;
          bus.core_data  = ph ^ am;
          @(posedge clk); #1;
          bus.core_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare DUT requests and samples against the scoreboard.
  always @(negedge clk) begin
    req_t r;
    smp_t s;
    if (!rst) begin
      if (bus.core_start) begin
        chk("core_start expected", exp_req.size() > 0, 1'b1);
        if (exp_req.size() > 0) begin
          r = exp_req.pop_front();
          chk("core_phase_o", bus.core_phase, r.ph);
          chk("core_amp_o", bus.core_amp, r.am);
        end
        if (bus.core_amp == 8'h55) start_cyc = cyc;
      end
      if (sample_valid) begin
        chk("sample_valid expected", exp_smp.size() > 0, 1'b1);
        if (exp_smp.size() > 0) begin
          s = exp_smp.pop_front();
          chk("sample_ch_o", sample_ch, s.ch);
          chk("sample_o", sample, s.d);
        end
      end
      if (frame_done) frame_cnt++;
      if (timeout && !to_prev) to_cyc = cyc;
      to_prev = timeout;
    end
  end

  initial begin
    logic [7:0] ph_tab [4];
    ph_tab = '{8'h10, 8'h20, 8'h30, 8'h40};

    // Reset values
    idle(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Single channel, four ticks
    cfg(2'd0, 2'd0, 8'h10);
    cfg(2'd0, 2'd1, 8'h7F);
    for (int k = 0; k < 4; k++) begin
      push(ph_tab[k], 8'h7F, 2'd0, 1'b0);
      do_tick(4'b0001);
      wait_frame(k + 1);
    end

    // Wrap and service order 0,1,3
    cfg(2'd1, 2'd0, 8'h08);
    cfg(2'd1, 2'd1, 8'h11);
    cfg(2'd3, 2'd0, 8'h70);
    cfg(2'd3, 2'd1, 8'h33);
    cfg(2'd3, 2'd2, 8'h20);
    push(8'h50, 8'h7F, 2'd0, 1'b0);
    push(8'h08, 8'h11, 2'd1, 1'b0);
    push(8'h90, 8'h33, 2'd3, 1'b0);
    do_tick(4'b1011);
    wait_frame(5);
    chk("last sample_ch_o", sample_ch, 2'd3);
    chk("last sample_o", sample, 8'hA3);

    // Overrun: dropped tick, clear, then clear colliding with a new overrun
    push(8'h60, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    idle(4);
    chk("overrun before", overrun, 1'b0);
    do_tick(4'b0001);
    chk("overrun set", overrun, 1'b1);
    wait_frame(6);
    pulse_clr();
    chk("overrun cleared", overrun, 1'b0);
    push(8'h70, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    idle(4);
    tick = 1'b1; status_clr = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; status_clr = 1'b0;
    chk("overrun set wins over clr", overrun, 1'b1);
    wait_frame(7);
    pulse_clr();
    chk("overrun cleared 2", overrun, 1'b0);

    // Timeout on ch1; ch2 still serviced
    cfg(2'd1, 2'd1, 8'h55);
    cfg(2'd2, 2'd0, 8'h04);
    cfg(2'd2, 2'd1, 8'h22);
    drop_en = 1'b1;
    push(8'h80, 8'h7F, 2'd0, 1'b0);
    push(8'h10, 8'h55, 2'd1, 1'b1);
    push(8'h04, 8'h22, 2'd2, 1'b0);
    chk("timeout before", timeout, 1'b0);
    do_tick(4'b0111);
    wait_frame(8);
    chk("timeout set", timeout, 1'b1);
    chk("timeout latency", to_cyc - start_cyc, 64);
    drop_en = 1'b0;
    pulse_clr();
    chk("timeout cleared", timeout, 1'b0);

    // inc write colliding with ch0 SCAN: old inc this frame, new next frame
    push(8'h90, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    cfg(2'd0, 2'd0, 8'h20);
    wait_frame(9);
    push(8'hB0, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    wait_frame(10);

    // accumulator load colliding with ch0 SCAN: load wins
    push(8'hD0, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    cfg(2'd0, 2'd2, 8'h05);
    wait_frame(11);
    push(8'h25, 8'h7F, 2'd0, 1'b0);
    do_tick(4'b0001);
    wait_frame(12);

    // Empty mask: frame_done only
    do_tick(4'b0000);
    idle(1);
    chk("empty mask frame_done", frame_cnt, 13);
    chk("empty mask busy", busy, 1'b0);
    idle(5);

    // Reset during WAIT: late core_valid must not publish
    push(8'h45, 8'h7F, 2'd0, 1'b1);
    do_tick(4'b0001);
    idle(5);
    chk("busy in WAIT", busy, 1'b1);
    rst = 1'b1;
    #2;
    chk_reset_outputs("mid-frame reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(30);
    chk("busy after reset", busy, 1'b0);

    chk("request queue drained", exp_req.size(), 0);
    chk("sample queue drained", exp_smp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wave_channel_scheduler.md
Name: wave_channel_scheduler

Overview:
- Time-multiplexes one CORDIC sine/cosine core among NUM_CH independent tone channels.
- Each channel has its own phase-increment register, amplitude register and phase accumulator.
- On every sample tick the block walks the enabled channels in ascending index order. For each one it advances the accumulator, issues the angle and amplitude to the core, waits for the result and publishes it tagged with the channel index.
- Sits between the register/config interface and the shared CORDIC core in the wave generator top level.

Parameters:
- NUM_CH, 4: number of channels; power of two, ≥2.
- N_FRAC, 7: fractional bits; all data words are N_FRAC+1 bits, two's complement.
- TIMEOUT, 64: maximum cycles to wait for core_valid_i before a channel is abandoned.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- tick_i  in  1  sample-rate strobe; starts one frame
- enable_i  in  NUM_CH  per-channel enable mask; sampled on an accepted tick
- cfg_we_i  in  1  config write strobe
- cfg_ch_i  in  clog2(NUM_CH)  target channel of the write
- cfg_sel_i  in  2  0 = phase increment, 1 = amplitude, 2 = accumulator load, 3 = reserved (write ignored)
- cfg_data_i  in  N_FRAC+1  write data
- core_start_o  out  1  one-cycle strobe; core_phase_o and core_amp_o are valid in the same cycle
- core_phase_o  out  N_FRAC+1  angle sent to the core
- core_amp_o  out  N_FRAC+1  amplitude sent to the core
- core_valid_i  in  1  core result strobe
- core_data_i  in  N_FRAC+1  core result
- sample_o  out  N_FRAC+1  published sample
- sample_ch_o  out  clog2(NUM_CH)  channel index of sample_o
- sample_valid_o  out  1  one-cycle strobe for sample_o / sample_ch_o
- frame_done_o  out  1  one-cycle strobe at the end of a frame
- busy_o  out  1  high while not IDLE
- status_clr_i  in  1  clears the sticky status flags
- overrun_o  out  1  sticky: tick_i arrived while busy
- timeout_o  out  1  sticky: a core request was abandoned

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; all inc, amp and acc registers 0; FSM to IDLE; latched mask 0; pointer 0.
- Reset mid-frame aborts the frame; any later core_valid_i is ignored because the FSM is in IDLE.

FSM states: IDLE, SCAN, WAIT.
- IDLE: on tick_i=1 latch enable_i into mask and set ptr=0.
  - If the mask is 0: pulse frame_done_o next cycle and stay in IDLE.
  - Otherwise go to SCAN.
- SCAN: select ch = the lowest set mask bit with index ≥ ptr.
  - If none: pulse frame_done_o and go to IDLE.
  - Else register acc[ch] ← acc[ch]+inc[ch] (mod 2^(N_FRAC+1), natural wrap), core_phase_o ← the new acc value, core_amp_o ← amp[ch], core_start_o ← 1 for exactly one cycle; clear the wait counter; go to WAIT.
- WAIT: increment the wait counter each cycle.
  - On core_valid_i: register sample_o ← core_data_i, sample_ch_o ← ch, pulse sample_valid_o; set ptr=ch+1; go to SCAN.
  - If the counter reaches TIMEOUT without core_valid_i: set timeout_o, publish nothing, set ptr=ch+1, go to SCAN.
  - core_valid_i and timeout in the same cycle: the valid wins.

Timing:
- core_start_o is high 2 cycles after tick_i is sampled.
- sample_valid_o is high 1 cycle after core_valid_i.
- The next core_start_o follows 2 cycles after that.
- frame_done_o is high 1 cycle after the last SCAN.
- Minimum frame length for k enabled channels with core latency L: 1 + k·(L+2) + 1 cycles.

Other rules:
- core_phase_o and core_amp_o hold their values between requests.
- core_valid_i is ignored outside WAIT.
- tick_i while busy_o=1 is dropped and sets overrun_o.
- A new mask is only taken at the next accepted tick.
- Config writes are accepted in any state.
  - inc/amp writes take effect at the channel's next SCAN; a write in the same cycle as that SCAN uses the old value.
  - An accumulator load in the same cycle as a SCAN update of the same channel: the config write wins.
- status_clr_i clears overrun_o and timeout_o. A flag event in the same cycle as status_clr_i sets the flag (set wins).
- Wait counter width is clog2(TIMEOUT+1).

Test Plan:
- Reset values: all outputs 0; assert rst_i mid-WAIT → FSM returns to IDLE, later core_valid_i produces no sample_valid_o.
- Single channel: inc[0]=0x10, amp[0]=0x7F, mask=0001, four ticks, core model latency 16 → core_phase_o = 0x10, 0x20, 0x30, 0x40; one sample per tick with sample_ch_o=0; frame_done_o once per tick.
- Wrap and order: mask=1011, inc[3]=0x70, acc[3] loaded to 0x20 → service order 0,1,3; acc[3] becomes 0x90 (wraps, no saturation); sample_ch_o sequence 0,1,3.
- Overrun: second tick_i during WAIT → tick dropped, overrun_o=1; status_clr_i → 0; clr in the same cycle as a new overrun → stays 1.
- Timeout: core model never returns for ch1, TIMEOUT=64 → timeout_o=1 after 64 WAIT cycles; no sample for ch1; ch2 is still serviced; frame_done_o still pulses.
- Config collision: an inc[0] write in the cycle of ch0's SCAN → old inc used this frame, new inc used next frame; mask=0000 tick → only frame_done_o, no core_start_o.
